nibble_serial_add_ctrl: RTL
===========================

// Module: nibble_serial_add_ctrl
// PURPOSE
//   Sequencer that time-shares one external 4-bit ripple-carry adder slice
//   (a 4-bit adder exposing all four ripple carries) to add or subtract
//   NIBBLES*4-bit operands, one nibble per clock, LSB nibble first.
//   It latches the operands on start, drives the slice, chains the carry
//   through a register and collects the result nibbles.
//   The slice is instantiated beside this block in the parent.
// PARAMETERS
//   NIBBLES  4  operand width in nibbles; W = 4*NIBBLES; legal 2..8
// PORTS
//   clock    in   1   rising-edge clock
//   reset    in   1   synchronous, active-high reset
//   start    in   1   request; accepted only in IDLE
//   sub      in   1   0 = a+b, 1 = a-b; sampled with start
//   a        in   W   operand A; sampled with start
//   b        in   W   operand B; sampled with start
//   add_a    out  4   nibble of A driven to the slice
//   add_b    out  4   nibble of B (inverted when sub) driven to the slice
//   add_cin  out  1   carry-in driven to the slice
//   add_s    in   4   sum returned by the slice (combinational)
//   add_c    in   4   ripple carries from the slice; [3] = carry-out
//   busy     out  1   high in RUN
//   done     out  1   one-cycle pulse when the result is valid
//   sum      out  W   result; held until the next accepted start
//   c_out    out  1   final carry (for sub: 1 = no borrow)
//   ovf      out  1   signed overflow, add_c[3]^add_c[2] on the last nibble
// BEHAVIOUR
//   - Reset (any state, mid-operation included): state=IDLE, idx=0,
//     carry reg=0. All outputs 0: busy, done, sum, c_out, ovf, add_*.
//   - FSM states: IDLE, RUN, DONE.
//     IDLE -start-> RUN.  RUN -idx==NIBBLES-1-> DONE.  DONE -> IDLE
//     unconditionally.
//   - Accept in IDLE: latch a, b and sub; idx<=0; carry<=sub.
//     sum, c_out and ovf are cleared on the accepting edge.
//   - RUN (per cycle, idx = i):
//     add_a   = a_r[4i+3:4i]
//     add_b   = b_r[4i+3:4i] ^ {4{sub_r}}
//     add_cin = carry
//     On the edge: sum[4i+3:4i]<=add_s; carry<=add_c[3]; idx<=idx+1.
//     On the last nibble also: c_out<=add_c[3]; ovf<=add_c[3]^add_c[2].
//   - add_a, add_b and add_cin are 0 outside RUN.
//   - DONE: done=1 for exactly one cycle; busy=0.
//   - Latency: start sampled at edge 0 -> busy for cycles 1..NIBBLES;
//     done high in cycle NIBBLES+1. Throughput is one operation per
//     NIBBLES+2 cycles.
//   - start is ignored in RUN and in DONE (it is not queued); operands
//     change in those states has no effect.
//   - idx wraps to 0 on leaving RUN. There are no X states: an unused
//     encoding returns to IDLE.
//   - Arithmetic is modulo 2^W. Subtract = a + ~b + 1.
// TESTING (NIBBLES=4)
//   1. add 0x1234+0x0FFF, start at edge 0 -> busy cycles 1-4, done
//      cycle 5, sum=0x2233, c_out=0, ovf=0.
//   2. add 0xFFFF+0x0001 -> sum=0x0000, c_out=1, ovf=0 (carry ripples
//      through all nibbles).
//   3. add 0x7FFF+0x0001 -> sum=0x8000, c_out=0, ovf=1.
//   4. sub 0x0005-0x0007 -> sum=0xFFFE, c_out=0, ovf=0.
//      sub 0x8000-0x0001 -> sum=0x7FFF, c_out=1, ovf=1.
//   5. start pulsed again in a RUN cycle and in the DONE cycle with
//      different operands -> ignored; the first result is unchanged and
//      exactly one done pulse is produced.
//   6. reset asserted at RUN idx=2 -> next cycle all outputs 0, IDLE;
//      a new start then completes normally with done at +5.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_if.sv
// Request/result and adder-slice signals of the nibble-serial add/sub sequencer.
// slave = the sequencer; master = the parent that owns the slice and issues requests.
interface nibble_serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_s;
  logic [3:0]   add_c;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  modport slave (
    input  start, sub, a, b, add_s, add_c,
    output add_a, add_b, add_cin, busy, done, sum, c_out, ovf
  );

  modport master (
    output start, sub, a, b, add_s, add_c,
    input  add_a, add_b, add_cin, busy, done, sum, c_out, ovf
  );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// Time-shares an external 4-bit ripple adder slice to add/subtract NIBBLES*4-bit
// operands, one nibble per clock, LSB nibble first.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  nibble_serial_add_ctrl_if.slave bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] idx_inc_s;
  logic          last_s;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic          sub_r;
  logic [W-1:0]  sum_r;
  logic          c_out_r;
  logic          ovf_r;
  logic          busy_r;
  logic          done_r;
  logic [3:0]    add_a_r;
  logic [3:0]    add_b_r;
  logic          add_cin_r;

  assign last_s    = (idx_r == IW'(NIBBLES - 1));
  assign idx_inc_s = idx_r + {{(IW-1){1'b0}}, 1'b1};

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; an unused encoding falls back to IDLE
  always_comb begin
    state_next_s = IDLE;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Status flags registered from the next state so they align with it
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s == RUN);
      done_r <= (state_next_s == DONE);
    end
  end

  // Operand capture, slice drive and result collection.
  // add_cin_r doubles as the inter-nibble carry register.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx_r     <= '0;
      a_r       <= '0;
      b_r       <= '0;
      sub_r     <= 1'b0;
      sum_r     <= '0;
      c_out_r   <= 1'b0;
      ovf_r     <= 1'b0;
      add_a_r   <= 4'h0;
      add_b_r   <= 4'h0;
      add_cin_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_r       <= bus.a;
            b_r       <= bus.b;
            sub_r     <= bus.sub;
            idx_r     <= '0;
            sum_r     <= '0;
            c_out_r   <= 1'b0;
            ovf_r     <= 1'b0;
            add_a_r   <= bus.a[3:0];
            add_b_r   <= bus.b[3:0] ^ {4{bus.sub}};
            add_cin_r <= bus.sub;
          end
        end
        RUN: begin
          sum_r[{idx_r, 2'b00} +: 4] <= bus.add_s;
          if (last_s) begin
            idx_r     <= '0;
            c_out_r   <= bus.add_c[3];
            ovf_r     <= bus.add_c[3] ^ bus.add_c[2];
            add_a_r   <= 4'h0;
            add_b_r   <= 4'h0;
            add_cin_r <= 1'b0;
          end else begin
            idx_r     <= idx_inc_s;
            add_a_r   <= a_r[{idx_inc_s, 2'b00} +: 4];
            add_b_r   <= b_r[{idx_inc_s, 2'b00} +: 4] ^ {4{sub_r}};
            add_cin_r <= bus.add_c[3];
          end
        end
        DONE: begin
          idx_r <= '0;
        end
        default: begin
          idx_r     <= '0;
          add_a_r   <= 4'h0;
          add_b_r   <= 4'h0;
          add_cin_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.add_a   = add_a_r;
  assign bus.add_b   = add_b_r;
  assign bus.add_cin = add_cin_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.sum     = sum_r;
  assign bus.c_out   = c_out_r;
  assign bus.ovf     = ovf_r;
endmodule
